// File: rtl/rv_fifo.sv
// rv_fifo: ready/valid FIFO, DEPTH x WIDTH, pointer-based with a wrap bit.
// Latency: one cycle from push to out_valid. With RV_FIFO_BYPASS_EN defined, an
//          empty FIFO passes in_data straight to out_data in zero cycles.
// Backpressure: in_ready = !full & !rst, registered-path only (no out_ready -> in_ready path).
module rv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             rd_en;

  // Status flags from the pointers; the extra MSB distinguishes full from empty.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  end

  // Producer side: ready depends only on stored state and reset, never on out_ready.
  always_comb begin
    in_ready = !full && !rst;
    push     = in_valid && in_ready;
  end

`ifdef RV_FIFO_BYPASS_EN
  // Consumer side with bypass: an empty FIFO presents the incoming word directly;
  // a word consumed in that same cycle is never written to storage.
  always_comb begin
    out_valid = !rst && (!empty || in_valid);
    out_data  = '0;
    if (out_valid) begin
      out_data = empty ? in_data : mem[rd_ptr[AW-1:0]];
    end
    pop   = out_valid && out_ready;
    wr_en = push && !(empty && out_ready);
    rd_en = pop && !empty;
  end
`else
  // Consumer side: out_valid/out_data depend only on stored state (plus reset).
  always_comb begin
    out_valid = !empty && !rst;
    out_data  = '0;
    if (out_valid) begin
      out_data = mem[rd_ptr[AW-1:0]];
    end
    pop   = out_valid && out_ready;
    wr_en = push;
    rd_en = pop;
  end
`endif

  // Storage array: written on an accepted push, never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Pointers advance on write/read and wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
    end
  end

  // Occupancy count: up on write-only, down on read-only, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

endmodule
